tdm_demux4_rx: RTL and testbench



---
 rtl/tdm_demux4_rx_pkg.sv | 18 +
 rtl/tdm_demux4_rx_demux1to4.sv | 28 ++
 rtl/tdm_demux4_rx.sv | 131 +++++++++++++
 tb/tb_tdm_demux4_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_rx_pkg.sv
// Shared definitions for the TDM receive path: FSM encoding and slot
// numbering, which are common with the transmitter-side 4:1 mux.
package tdm_demux4_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam int                SLOT_W    = 2;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;

  // Slot index of the word following slot s.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_demux4_rx_demux1to4.sv
// Slot index to one-hot write-enable decoder. A word is written into a slot
// only when it is valid and not a frame-start word. This is the inverse of
// the transmitter's 4:1 slot select.
module demux1to4
  import tdm_demux4_rx_pkg::*;
(
  input  logic              valid,
  input  logic              sync,
  input  logic [SLOT_W-1:0] sel,
  output logic              e0,
  output logic              e1,
  output logic              e2,
  output logic              e3
);

  logic en;

  assign en = valid & ~sync;

  // Exactly one enable is raised for the selected slot when en is set.
  always_comb begin
    e0 = en && (sel == 2'd0);
    e1 = en && (sel == 2'd1);
    e2 = en && (sel == 2'd2);
    e3 = en && (sel == 2'd3);
  end

endmodule

// File: rtl/tdm_demux4_rx.sv
// Receive end of the 4-channel TDM link. Collects slot words 0..3 into
// shadow registers and copies the complete frame to ch0..ch3 in one edge,
// so the channel outputs never show a half-updated frame.
module tdm_demux4_rx
  import tdm_demux4_rx_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic             din_sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_done,
  output logic             sync_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e                  state_q,  state_d;
  logic [SLOT_W-1:0]       slot_q,   slot_d;
  // Slot 3 is never shadowed: it goes straight from din to ch3 on commit.
  logic [2:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [3:0][WIDTH-1:0]   ch_q,     ch_d;
  logic                    frame_done_q, frame_done_d;
  logic                    sync_err_q,   sync_err_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [3:0]              wr_en;

  demux1to4 u_demux (
    .valid (din_valid),
    .sync  (din_sync),
    .sel   (slot_q),
    .e0    (wr_en[0]),
    .e1    (wr_en[1]),
    .e2    (wr_en[2]),
    .e3    (wr_en[3])
  );

  // Next-state logic for the frame assembler, shadows, channels and counter.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (din_valid && din_sync) begin
          shadow_d[0] = din;
          slot_d      = 2'd1;
          state_d     = ST_RECV;
        end else if (wr_en[0]) begin
          // Non-sync word with no frame open: dropped and flagged.
          sync_err_d = 1'b1;
        end
      end

      ST_RECV: begin
        if (din_valid && din_sync) begin
          // Early sync: abandon the partial frame, restart at slot 0.
          sync_err_d  = 1'b1;
          shadow_d[0] = din;
          slot_d      = 2'd1;
        end else if (wr_en[LAST_SLOT]) begin
          ch_d[0]      = shadow_q[0];
          ch_d[1]      = shadow_q[1];
          ch_d[2]      = shadow_q[2];
          ch_d[3]      = din;
          frame_done_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          slot_d       = 2'd0;
          state_d      = ST_IDLE;
        end else if (wr_en[1]) begin
          shadow_d[1] = din;
          slot_d      = next_slot(slot_q);
        end else if (wr_en[2]) begin
          shadow_d[2] = din;
          slot_d      = next_slot(slot_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the shadow and channel registers are real flops, not a memory,
    // so they are cleared on reset like the rest; outputs must read 0.
    if (!resetn) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      shadow_q     <= '0;
      ch_q         <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      ch_q         <= ch_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign busy       = (state_q == ST_RECV);
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Scoreboard bench for tdm_demux4_rx (WIDTH=4, CNT_W=2 so the counter wraps).
// The stimulus side feeds each accepted word to a frame-level model that
// pushes expected events; a negedge monitor pops and compares them.
module tb_tdm_demux4_rx;

  localparam int W       = 4;
  localparam int CW      = 2;
  localparam int CNT_MOD = 1 << CW;

  typedef struct {
    bit         is_frame;
    logic [W-1:0] ch [4];
    int         cnt;
  } ev_t;

  logic          clock = 1'b0;
  logic          resetn;
  logic          din_valid, din_sync;
  logic [W-1:0]  din;
  logic [W-1:0]  ch0, ch1, ch2, ch3;
  logic          frame_done, sync_err, busy;
  logic [CW-1:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  // Model state (frame-level view).
  logic [W-1:0] partial [$];
  int           model_cnt;
  ev_t          exp_q [$];

  // What the outputs should currently hold, advanced by the monitor.
  logic [W-1:0] mon_ch [4];
  int           mon_cnt;

  tdm_demux4_rx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .din        (din),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the protocol rules to one accepted word.
  task automatic model_word(input bit s, input logic [W-1:0] d);
    ev_t e;
    if (s) begin
      if (partial.size() > 0) begin
        e.is_frame = 1'b0;
        exp_q.push_back(e);
      end
      partial.delete();
      partial.push_back(d);
    end else if (partial.size() == 0) begin
      e.is_frame = 1'b0;
      exp_q.push_back(e);
    end else begin
      partial.push_back(d);
      if (partial.size() == 4) begin
        model_cnt  = (model_cnt + 1) % CNT_MOD;
        e.is_frame = 1'b1;
        for (int i = 0; i < 4; i++) e.ch[i] = partial[i];
        e.cnt = model_cnt;
        exp_q.push_back(e);
        partial.delete();
      end
    end
  endtask

  // Drive one cycle of input (entered and left at posedge+1).
  task automatic send(input bit v, input bit s, input logic [W-1:0] d);
    din_valid = v;
    din_sync  = s;
    din       = d;
    if (v) model_word(s, d);
    @(posedge clock);
    #1;
    din_valid = 1'b0;
    din_sync  = 1'b0;
    check("busy", {31'b0, busy}, {31'b0, partial.size() > 0});
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, d);
    send(1, 1, a);
    send(1, 0, b);
    send(1, 0, c);
    send(1, 0, d);
  endtask

  // Async reset away from any clock edge, checked before the next edge.
  task automatic do_reset();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    partial.delete();
    model_cnt = 0;
    mon_cnt   = 0;
    for (int i = 0; i < 4; i++) mon_ch[i] = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ch", {16'b0, ch0, ch1, ch2, ch3}, 32'd0);
    check("rst_cnt", {30'b0, frame_cnt}, 32'd0);
    check("rst_pending", exp_q.size(), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: pulses consume expected events; outputs must hold otherwise.
  always @(negedge clock) begin
    ev_t e;
    if (frame_done && sync_err) begin
      tests++;
      fails++;
      $display("FAIL both_pulses: frame_done=1 sync_err=1 expected not both at %0t", $time);
    end else if (frame_done || sync_err) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: frame_done=%0b sync_err=%0b expected none at %0t",
                 frame_done, sync_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'b0, frame_done}, {31'b0, e.is_frame});
        if (e.is_frame) begin
          for (int i = 0; i < 4; i++) mon_ch[i] = e.ch[i];
          mon_cnt = e.cnt;
        end
      end
    end
    check("ch", {16'b0, ch0, ch1, ch2, ch3},
          {16'b0, mon_ch[0], mon_ch[1], mon_ch[2], mon_ch[3]});
    check("frame_cnt", {30'b0, frame_cnt}, mon_cnt);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected done", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    din_valid = 1'b0;
    din_sync  = 1'b0;
    din       = '0;
    model_cnt = 0;
    mon_cnt   = 0;
    for (int i = 0; i < 4; i++) mon_ch[i] = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Reset then idle: nothing may move for 10 cycles.
    for (int i = 0; i < 10; i++) send(0, 0, '0);

    // Clean frame 1,0,1,1 on consecutive cycles.
    frame(4'h1, 4'h0, 4'h1, 4'h1);
    send(0, 0, '0);
    check("clean_ch", {16'b0, ch0, ch1, ch2, ch3}, 32'h1011);
    check("clean_cnt", {30'b0, frame_cnt}, 32'd1);

    // Gapped frame A, 5, F, 3 with idle gaps.
    send(1, 1, 4'hA);
    repeat (3) send(0, 0, '0);
    send(1, 0, 4'h5);
    send(0, 0, '0);
    send(1, 0, 4'hF);
    send(1, 0, 4'h3);
    send(0, 0, '0);
    check("gap_ch", {16'b0, ch0, ch1, ch2, ch3}, 32'hA5F3);

    // Early sync after a committed frame.
    frame(4'h1, 4'h1, 4'h1, 4'h1);
    send(1, 1, 4'h0);
    send(1, 0, 4'h0);
    frame(4'h1, 4'h0, 4'h0, 4'h1);
    send(0, 0, '0);
    check("early_ch", {16'b0, ch0, ch1, ch2, ch3}, 32'h1001);

    // Orphan word in IDLE, then reset in the middle of a frame.
    send(1, 0, 4'h7);
    send(0, 0, '0);
    send(1, 1, 4'h1);
    send(1, 0, 4'h1);
    do_reset();

    // Five back-to-back frames: counter runs 1,2,3,0,1.
    for (int f = 0; f < 5; f++)
      frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    send(0, 0, '0);
    check("wrap_cnt", {30'b0, frame_cnt}, 32'd1);

    // Random traffic: gaps, orphans, early syncs, full frames.
    for (int i = 0; i < 400; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      send(v, s, W'($urandom));
    end

    repeat (3) send(0, 0, '0);
    check("drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
